// File: rtl/lfsr_gen_if.sv
// ============================================================================
// lfsr_gen_if
// Request/status bundle for the LFSR generator: step/load/burst requests in,
// registered state and status flags out.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface lfsr_gen_if #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
);

  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  logic             wrap;
  logic             lock;

  // Requester side: drives requests, observes state and status
  modport master (
    output en, load, load_val, start, len,
    input  out, busy, done, wrap, lock
  );

  // Generator side
  modport slave (
    input  en, load, load_val, start, len,
    output out, busy, done, wrap, lock
  );

endinterface

`default_nettype wire

// File: rtl/lfsr_gen.sv
// ============================================================================
// lfsr_gen
// Parametrised Fibonacci LFSR with seed load, free-run enable, counted burst
// mode (busy/done), period-wrap pulse and all-zero lock flag.
// Optional feature macro: LFSR_LOCKUP_RECOVER_EN -- a step taken from the
// all-zero state reloads SEED (and the reference) instead of staying at 0.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module lfsr_gen #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'h9,
  parameter logic [WIDTH-1:0] SEED  = 4'h1,
  parameter int               LEN_W = 8
) (
  input  wire logic   clk,
  input  wire logic   rst,
  lfsr_gen_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] lfsr_nxt;
  logic [WIDTH-1:0] ref_q;
  logic [WIDTH-1:0] ref_nxt;
  // Steps still owed after the one being taken this cycle
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_nxt;
  logic             done_q;
  logic             done_nxt;
  logic             wrap_q;
  logic             wrap_nxt;
  logic             do_step;
  logic             recover;
  logic [WIDTH-1:0] stepped;

  // Candidate next state for a single step, including lock-up recovery
  always_comb begin
    stepped = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
    recover = 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
    if (lfsr == '0) begin
      stepped = SEED;
      recover = 1'b1;
    end
`endif
  end

  // Next-state: load beats burst step beats free-run step beats hold
  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    ref_nxt   = ref_q;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    wrap_nxt  = 1'b0;
    do_step   = 1'b0;

    if (bus.load) begin
      // Aborts any burst silently; no done pulse
      lfsr_nxt  = bus.load_val;
      ref_nxt   = bus.load_val;
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        BURST: begin
          do_step = 1'b1;
          if (cnt == LEN_W'(1)) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt - LEN_W'(1);
          end
        end
        default: begin
          if (bus.start && (bus.len != '0)) begin
            // First burst step happens on the accepting edge
            do_step = 1'b1;
            if (bus.len == LEN_W'(1)) begin
              done_nxt = 1'b1;
            end else begin
              state_nxt = BURST;
              cnt_nxt   = bus.len - LEN_W'(1);
            end
          end else begin
            // Zero-length burst completes immediately
            done_nxt = bus.start;
            do_step  = bus.en;
          end
        end
      endcase

      if (do_step) begin
        lfsr_nxt = stepped;
        if (recover) begin
          ref_nxt = SEED;
        end else begin
          wrap_nxt = (stepped == ref_q);
        end
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      lfsr   <= SEED;
      ref_q  <= SEED;
      cnt    <= '0;
      done_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      lfsr   <= lfsr_nxt;
      ref_q  <= ref_nxt;
      cnt    <= cnt_nxt;
      done_q <= done_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  assign bus.out  = lfsr;
  assign bus.busy = (state == BURST);
  assign bus.done = done_q;
  assign bus.wrap = wrap_q;
  assign bus.lock = (lfsr == '0);

endmodule

`default_nettype wire

// File: tb/tb_lfsr_gen.sv
// ============================================================================
// tb_lfsr_gen
// Self-checking bench for lfsr_gen: directed scenarios plus randomized
// traffic compared cycle by cycle against an arithmetic reference model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lfsr_gen;

  localparam int W    = 4;
  localparam int LW   = 8;
  localparam int TAPS = 'h9;
  localparam int SEED = 'h1;
`ifdef LFSR_LOCKUP_RECOVER_EN
  localparam bit RECOVER = 1'b1;
`else
  localparam bit RECOVER = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Reference model state
  int m_out;
  int m_ref;
  int m_rem;
  int m_done;
  int m_wrap;

  lfsr_gen_if #(.WIDTH(W), .LEN_W(LW)) bus ();

  lfsr_gen #(
    .WIDTH(W),
    .TAPS (4'h9),
    .SEED (4'h1),
    .LEN_W(LW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shift left by one, new LSB is the parity of the tapped bits
  function automatic int lfsr_next(input int s);
    int p;
    p = $countones(s & TAPS) % 2;
    return ((s * 2) % (1 << W)) + p;
  endfunction

  // Advance the model by one clock using the inputs currently applied
  task automatic model_edge();
    int n_out, n_ref, n_rem, n_done, n_wrap;
    bit stp;
    n_out = m_out; n_ref = m_ref; n_rem = m_rem; n_done = 0; n_wrap = 0; stp = 0;
    if (rst === 1'b0) begin
      n_out = SEED; n_ref = SEED; n_rem = 0;
    end else if (bus.load === 1'b1) begin
      n_out = int'(bus.load_val); n_ref = int'(bus.load_val); n_rem = 0;
    end else begin
      if (m_rem > 0) begin
        stp = 1; n_rem = m_rem - 1; n_done = (n_rem == 0);
      end else if (bus.start === 1'b1 && bus.len != 0) begin
        stp = 1; n_rem = int'(bus.len) - 1; n_done = (n_rem == 0);
      end else begin
        n_done = (bus.start === 1'b1);
        stp    = (bus.en === 1'b1);
      end
      if (stp) begin
        if (RECOVER && m_out == 0) begin
          n_out = SEED; n_ref = SEED;
        end else begin
          n_out  = lfsr_next(m_out);
          n_wrap = (n_out == m_ref);
        end
      end
    end
    m_out = n_out; m_ref = n_ref; m_rem = n_rem; m_done = n_done; m_wrap = n_wrap;
  endtask

  // One clock: update model, pass the edge, compare every output
  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    chk("out",  32'(bus.out),  32'(m_out));
    chk("busy", 32'(bus.busy), 32'(m_rem > 0));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("wrap", 32'(bus.wrap), 32'(m_wrap));
    chk("lock", 32'(bus.lock), 32'(m_out == 0));
  endtask

  task automatic set_in(input bit e, input bit ld, input int lv, input bit st, input int ln);
    bus.en       = e;
    bus.load     = ld;
    bus.load_val = W'(lv);
    bus.start    = st;
    bus.len      = LW'(ln);
  endtask

  initial begin
    int seq [15];
    int wcnt;
    checks = 0;
    errors = 0;
    m_out = SEED; m_ref = SEED; m_rem = 0; m_done = 0; m_wrap = 0;
    seq = '{'h3, 'h7, 'hF, 'hE, 'hD, 'hA, 'h5, 'hB, 'h6, 'hC, 'h9, 'h2, 'h4, 'h8, 'h1};

    // Reset state
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0);
    cyc();
    cyc();
    chk("rst_out", 32'(bus.out), 32'h1);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    rst = 1'b1;

    // Free run through the full period from the seed
    wcnt = 0;
    set_in(1, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      cyc();
      chk("seq", 32'(bus.out), 32'(seq[i]));
      if (bus.wrap === 1'b1) wcnt++;
    end
    chk("seq_wrap_last", 32'(bus.wrap), 32'h1);
    chk("seq_wrap_count", 32'(wcnt), 32'h1);

    // Load 5 then full period back to 5
    set_in(0, 1, 'h5, 0, 0);
    cyc();
    chk("load5", 32'(bus.out), 32'h5);
    chk("load5_wrap", 32'(bus.wrap), 32'h0);
    set_in(1, 0, 0, 0, 0);
    cyc();
    chk("load5_first", 32'(bus.out), 32'hB);
    wcnt = (bus.wrap === 1'b1) ? 1 : 0;
    for (int i = 1; i < 15; i++) begin
      cyc();
      if (bus.wrap === 1'b1) wcnt++;
    end
    chk("load5_back", 32'(bus.out), 32'h5);
    chk("load5_wrap_last", 32'(bus.wrap), 32'h1);
    chk("load5_wrap_count", 32'(wcnt), 32'h1);

    // Burst of 3 from 1
    set_in(0, 1, 'h1, 0, 0);
    cyc();
    set_in(0, 0, 0, 1, 3);
    cyc();
    chk("b3_s1", 32'(bus.out), 32'h3);
    chk("b3_busy1", 32'(bus.busy), 32'h1);
    set_in(0, 0, 0, 0, 0);
    cyc();
    chk("b3_s2", 32'(bus.out), 32'h7);
    chk("b3_busy2", 32'(bus.busy), 32'h1);
    cyc();
    chk("b3_s3", 32'(bus.out), 32'hF);
    chk("b3_busy3", 32'(bus.busy), 32'h0);
    chk("b3_done", 32'(bus.done), 32'h1);
    cyc();
    chk("b3_hold", 32'(bus.out), 32'hF);
    chk("b3_done_clr", 32'(bus.done), 32'h0);

    // Zero-length burst
    set_in(0, 0, 0, 1, 0);
    cyc();
    chk("b0_out", 32'(bus.out), 32'hF);
    chk("b0_done", 32'(bus.done), 32'h1);
    chk("b0_busy", 32'(bus.busy), 32'h0);
    set_in(0, 0, 0, 0, 0);
    cyc();

    // Burst of 5 with start held during the burst
    set_in(0, 0, 0, 1, 5);
    cyc();
    set_in(0, 0, 0, 1, 7);
    cyc();
    cyc();
    cyc();
    set_in(0, 0, 0, 0, 0);
    cyc();
    chk("b5_out", 32'(bus.out), 32'hB);
    chk("b5_done", 32'(bus.done), 32'h1);
    cyc();
    chk("b5_hold", 32'(bus.out), 32'hB);

    // Load during a burst of 10 after four steps
    set_in(0, 1, 'h1, 0, 0);
    cyc();
    set_in(0, 0, 0, 1, 10);
    cyc();
    set_in(0, 0, 0, 0, 0);
    cyc();
    cyc();
    cyc();
    chk("abort_pre", 32'(bus.out), 32'hE);
    set_in(0, 1, 'hC, 0, 0);
    cyc();
    chk("abort_out", 32'(bus.out), 32'hC);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    set_in(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc();

    // Reset during a burst
    set_in(0, 0, 0, 1, 10);
    cyc();
    set_in(0, 0, 0, 0, 0);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    chk("rst_mid_out", 32'(bus.out), 32'h1);
    chk("rst_mid_busy", 32'(bus.busy), 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) cyc();

    // Lock-up via load of zero
    set_in(0, 1, 0, 0, 0);
    cyc();
    chk("lock_set", 32'(bus.lock), 32'h1);
    set_in(1, 0, 0, 0, 0);
    cyc();
`ifdef LFSR_LOCKUP_RECOVER_EN
    chk("lock_recover_out", 32'(bus.out), 32'h1);
    chk("lock_recover_flag", 32'(bus.lock), 32'h0);
`else
    chk("lock_hold_out", 32'(bus.out), 32'h0);
    chk("lock_hold_flag", 32'(bus.lock), 32'h1);
`endif
    cyc();
    cyc();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      set_in(($urandom_range(0, 1) == 1),
             ($urandom_range(0, 99) < 6),
             int'($urandom_range(0, 15)),
             ($urandom_range(0, 99) < 15),
             int'($urandom_range(0, 12)));
      cyc();
    end
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised Fibonacci LFSR pseudo-random generator. It is the generalised successor to the fixed 4-bit LFSR and supports configurable width, tap mask and seed. It adds a seed-load port, free-run enable, a counted burst mode with busy/done handshake, period-wrap detection and an all-zero lock-up flag. It sits beside the core as a test-pattern and PRNG source on the VSDSquadron Mini designs.

## Interface
- WIDTH, 4: state width; legal range 3..32.
- TAPS, 4'h9: feedback tap mask, WIDTH bits; bit i set means out[i] enters the XOR. The default is x^4+x^3+1, maximal length.
- SEED, 4'h1: reset state; must be non-zero.
- LEN_W, 8: width of the burst length.
- clk  input  1  sole clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset.
- en  input  1  free-run step request; honoured only while not busy.
- load  input  1  load load_val into the state this cycle.
- load_val  input  WIDTH  value to load.
- start  input  1  burst request; accepted only when busy=0.
- len  input  LEN_W  number of steps in the burst; sampled with start.
- out  output  WIDTH  current LFSR state (registered).
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse at burst completion.
- wrap  output  1  one-cycle pulse when a step returns the state to the reference value.
- lock  output  1  level; high while out == 0.

## Operation
- Step rule: out <= {out[WIDTH-2:0], ^(out & TAPS)}.
- Reference register ref: set to SEED on reset and to load_val on load.
- Priority each cycle: reset > load > burst step > en step > hold.
- States: IDLE and BURST.
  - IDLE → BURST on start with len ≠ 0. The remaining-step counter is set to len.
  - IDLE + start with len == 0: no step, no BURST; done pulses next cycle.
  - BURST: one step per cycle and the counter decrements. en is ignored.
  - When the counter reaches 1, that step is taken and the block returns to IDLE. done pulses in the cycle after the final step, aligned with out showing the final state.
- start while busy: ignored; no queueing.
- load during BURST: the burst is aborted, the state takes load_val, and the block goes to IDLE. done does not pulse.
- wrap: registered. It is high in the cycle where out == ref as the result of a step. It is not raised by load or reset.
- lock: combinational from out == 0. With plain XOR feedback the zero state is a fixed point. It is reached only by loading 0.
- Reset values: out = SEED, ref = SEED, busy = 0, done = 0, wrap = 0, lock = 0, state = IDLE, counter = 0.

## Timing
- Load and step latency is 1 cycle: the new state appears on out the edge after the request.
- In a burst of len = N, steps occur on edges 1..N after the start edge. busy is high from edge 1 through edge N−1 inclusive, and done is high for the cycle after edge N.
- Back-to-back bursts: start may be asserted in the cycle done is high, since busy = 0 then. The next burst then begins without a gap.
- Period for WIDTH=4, TAPS=4'h9 is 15 steps. wrap fires every 15th step.
- Reset asserted mid-burst: all state returns to reset values on that edge, and no done pulse is produced.

## Configuration
- LFSR_LOCKUP_RECOVER_EN defined: a step taken from out == 0 loads SEED instead of 0, and also sets ref to SEED. lock clears on the following cycle.
- LFSR_LOCKUP_RECOVER_EN undefined: out == 0 holds at 0 indefinitely under steps. lock stays high until a non-zero load or reset.

## Test plan
- Reset then en=1 for 15 cycles (defaults) → out visits 1,3,7,F,E,D,A,5,B,6,C,9,2,4,8 then 1. wrap pulses exactly once, on the return to 1.
- load=1, load_val=4'h5, then en=1 for 15 cycles → next out is B. wrap fires when out returns to 5, after 15 steps.
- start with len=3 from out=1 while en=0 → busy for 2 cycles, out 3,7,F. done pulses with out=F, and out holds afterwards.
- start with len=0 → no state change and done pulses 1 cycle later. A second start during a len=5 burst is ignored, and total steps = 5.
- load 4'hC mid-burst with len=10 at step 4 → out=C next cycle, busy=0, and no done pulse. rst=0 mid-burst → out=1, busy=0.
- load 0 then en=1 → lock=1. With the macro: out=1 next step and lock clears. Without the macro: out stays 0 and lock stays 1.
